// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin, packet-granular arbiter that shares the single UART TX byte
// stream between PORTS requester streams (command responder, event dumper,
// status reporter, ...). A grant is held from the first beat of a packet up
// to its tlast beat so bytes from different sources never interleave. A stall
// watchdog revokes the grant of a requester that stops sending mid-packet.
//
// Ports:
//   clk          core clock
//   rst          asynchronous active-high reset
//   s_tdata      requester data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid     requester valid, one bit per port
//   s_tlast      requester end-of-packet, one bit per port
//   s_tready     requester ready, only the granted port can see m_tready
//   m_tdata      byte to the UART TX stream
//   m_tvalid     valid to the UART TX stream
//   m_tlast      end-of-packet to the UART TX stream
//   m_tready     ready from the UART TX stream
//   grant        one-hot grant, zero while idle
//   busy         high while a grant is held
//   timeout_err  one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int PORTS      = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORTS-1:0]            s_tvalid,
    input  logic [PORTS-1:0]            s_tlast,
    output logic [PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [PORTS-1:0]            grant,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]            state;
    logic [PTR_W-1:0]      ptr;
    logic [CNT_W-1:0]      wd_cnt;
    logic [PORTS-1:0]      grant_q;
    logic                  terr_q;

    logic [DATA_WIDTH-1:0] port_data [PORTS];

    logic                  any_req;
    logic [PTR_W-1:0]      next_idx;

    logic                  in_xfer;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  beat;
    logic                  stall;
    logic                  wd_expire;

    // Unpack the flat data bus so the selected port can be picked by index.
    for (genvar g = 0; g < PORTS; g++) begin : g_unpack
        assign port_data[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: start just after the last-served port and wrap, so
    // the port served most recently is always considered last.
    always_comb begin : arb_search
        int               idx;
        logic [PTR_W-1:0] idx_b;
        any_req  = 1'b0;
        next_idx = ptr;
        idx      = 0;
        idx_b    = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx   = (int'(ptr) + k) % PORTS;
            idx_b = PTR_W'(idx);
            if (!any_req && s_tvalid[idx_b]) begin
                any_req  = 1'b1;
                next_idx = idx_b;
            end
        end
    end

    // While a grant is held the pointer doubles as the selected port index.
    assign in_xfer   = (state == ST_XFER);
    assign cur_valid = s_tvalid[ptr];
    assign cur_last  = s_tlast[ptr];
    assign beat      = in_xfer & cur_valid & m_tready;
    // Only a missing valid is a stall; backpressure from downstream is not.
    assign stall     = in_xfer & ~cur_valid;
    assign wd_expire = (TIMEOUT > 0) && stall && (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Combinational pass-through of the granted port; everything is held at
    // zero while idle.
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        if (in_xfer) begin
            s_tready[ptr] = m_tready;
            m_tvalid      = cur_valid;
            m_tdata       = port_data[ptr];
            m_tlast       = cur_last;
        end
    end

    // Arbitration state, grant register and stall watchdog. On a watchdog
    // revoke the pointer already names the offending port, so it becomes the
    // lowest priority in the next round without an explicit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= PTR_W'(PORTS - 1);
            wd_cnt  <= '0;
            grant_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_XFER;
                        ptr     <= next_idx;
                        grant_q <= {{(PORTS-1){1'b0}}, 1'b1} << next_idx;
                        wd_cnt  <= '0;
                    end
                end
                ST_XFER: begin
                    if (beat) begin
                        wd_cnt <= '0;
                        if (cur_last) begin
                            state   <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end else if (wd_expire) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        terr_q  <= 1'b1;
                        wd_cnt  <= '0;
                    end else if (stall && (TIMEOUT > 0)) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = in_xfer;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (PORTS=3, TIMEOUT=16). Requesters
// are modelled as byte queues; a behavioural arbiter model (owner index,
// last-served index, stall count) predicts every output each cycle, and the
// directed steps additionally compare the collected output byte stream and
// grant order against values built from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int PORTS = 3;
    localparam int DW    = 8;
    localparam int TMO   = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_tdata;
    logic [PORTS-1:0]      s_tvalid;
    logic [PORTS-1:0]      s_tlast;
    logic [PORTS-1:0]      s_tready;
    logic [DW-1:0]         m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic                  m_tready;
    logic [PORTS-1:0]      grant;
    logic                  busy;
    logic                  timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner = granted port or -1, last = last-served port.
    int   md_owner;
    int   md_last;
    int   md_stall;
    logic md_terr;

    logic [8:0]       txq [PORTS][$];
    logic [PORTS-1:0] hold;
    logic [8:0]       out_log [$];
    logic [PORTS-1:0] grant_log [$];
    logic [PORTS-1:0] prev_grant;
    logic [PORTS-1:0] hs;
    int               terr_count;

    uart_tx_arbiter #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO),
        .CNT_W      (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_owner = -1;
        md_last  = PORTS - 1;
        md_stall = 0;
        md_terr  = 1'b0;
    endtask

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < PORTS; i++) begin
            if (txq[i].size() > 0 && !hold[i]) begin
                h = txq[i][0];
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = h[7:0];
                s_tlast[i]           = h[8];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
                s_tlast[i]           = 1'b0;
            end
        end
    endtask

    task automatic check_output();
        logic [PORTS-1:0] e_grant;
        logic [PORTS-1:0] e_ready;
        logic             e_valid;
        logic [DW-1:0]    e_data;
        logic             e_last;
        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = '0;
        e_last  = 1'b0;
        if (md_owner >= 0) begin
            e_grant[md_owner] = 1'b1;
            e_ready[md_owner] = m_tready;
            e_valid           = s_tvalid[md_owner];
            e_data            = s_tdata[md_owner*DW +: DW];
            e_last            = s_tlast[md_owner];
        end
        check_val("grant",       32'(grant),       32'(e_grant));
        check_val("busy",        32'(busy),        32'(md_owner >= 0));
        check_val("m_tvalid",    32'(m_tvalid),    32'(e_valid));
        check_val("m_tdata",     32'(m_tdata),     32'(e_data));
        check_val("m_tlast",     32'(m_tlast),     32'(e_last));
        check_val("s_tready",    32'(s_tready),    32'(e_ready));
        check_val("timeout_err", 32'(timeout_err), 32'(md_terr));
    endtask

    // Advance the model by one clock edge using the inputs presented.
    task automatic model_update();
        bit found;
        int p;
        md_terr = 1'b0;
        if (md_owner < 0) begin
            found = 0;
            for (int k = 1; k <= PORTS; k++) begin
                p = (md_last + k) % PORTS;
                if (!found && s_tvalid[p]) begin
                    found    = 1;
                    md_owner = p;
                    md_last  = p;
                    md_stall = 0;
                end
            end
        end else if (s_tvalid[md_owner] && m_tready) begin
            md_stall = 0;
            if (s_tlast[md_owner]) md_owner = -1;
        end else if (!s_tvalid[md_owner]) begin
            md_stall++;
            if (md_stall == TMO) begin
                md_owner = -1;
                md_terr  = 1'b1;
                md_stall = 0;
            end
        end
    endtask

    task automatic tick();
        drive_inputs();
        @(negedge clk);
        check_output();
        if (m_tvalid && m_tready) out_log.push_back({m_tlast, m_tdata});
        if (timeout_err) terr_count++;
        if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        prev_grant = grant;
        hs = s_tready & s_tvalid;
        @(posedge clk);
        model_update();
        for (int i = 0; i < PORTS; i++) begin
            if (hs[i]) void'(txq[i].pop_front());
        end
        #1;
    endtask

    task automatic push_packet(input int port, input int len, input logic [7:0] base);
        for (int j = 0; j < len; j++) begin
            txq[port].push_back({(j == len - 1), 8'(base + 8'(j))});
        end
    endtask

    task automatic drain(input int max_cycles, input string tag);
        int  n;
        bit  empty;
        n     = 0;
        empty = 0;
        while (!empty && n < max_cycles) begin
            empty = (md_owner < 0);
            for (int i = 0; i < PORTS; i++) if (txq[i].size() > 0) empty = 0;
            if (!empty) begin
                tick();
                n++;
            end
        end
        empty = (md_owner < 0);
        for (int i = 0; i < PORTS; i++) if (txq[i].size() > 0) empty = 0;
        check_val(tag, 32'(empty), 32'd1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        grant_log.delete();
        terr_count = 0;
    endtask

    initial begin
        logic [8:0] exp_b;
        int         port_seq;

        rst      = 1'b1;
        m_tready = 1'b0;
        hold     = '0;
        prev_grant = '0;
        terr_count = 0;
        model_reset();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Step 1: reset release with no requests.
        $display("[TB] reset and idle");
        check_val("rst_grant",    32'(grant),    32'd0);
        check_val("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        repeat (20) tick();

        // Step 2: port 1 alone sends 0x41,0x42,0x43.
        $display("[TB] single port packet");
        clear_logs();
        m_tready = 1'b1;
        push_packet(1, 3, 8'h41);
        tick();
        check_val("p1_grant", 32'(grant), 32'b010);
        drain(20, "p1_drain");
        check_val("p1_len", 32'(out_log.size()), 32'd3);
        for (int j = 0; j < 3 && j < out_log.size(); j++) begin
            exp_b = {(j == 2), 8'(8'h41 + 8'(j))};
            check_val("p1_byte", 32'(out_log[j]), 32'(exp_b));
        end
        check_val("p1_grant_end", 32'(grant), 32'd0);

        // Step 3: all ports with two 2-byte packets each. Port 1 was served
        // last, so the rotation starts at port 2.
        $display("[TB] round robin");
        clear_logs();
        for (int i = 0; i < PORTS; i++)
            for (int r = 0; r < 2; r++) push_packet(i, 2, 8'(8'h10 * (i + 1) + 8'(r * 2)));
        drain(80, "rr_drain");
        check_val("rr_len", 32'(out_log.size()), 32'd12);
        check_val("rr_pkts", 32'(grant_log.size()), 32'd6);
        for (int n = 0; n < 6 && n < grant_log.size(); n++) begin
            port_seq = (2 + n) % PORTS;
            check_val("rr_order", 32'(grant_log[n]), 32'(1 << port_seq));
            for (int j = 0; j < 2 && (2 * n + j) < out_log.size(); j++) begin
                exp_b = {(j == 1), 8'(8'h10 * (port_seq + 1) + 8'((n / 3) * 2 + j))};
                check_val("rr_byte", 32'(out_log[2 * n + j]), 32'(exp_b));
            end
        end

        // Step 4: port 2 packet with 50 cycles of downstream backpressure.
        $display("[TB] backpressure");
        clear_logs();
        push_packet(2, 3, 8'hA0);
        tick();
        tick();
        m_tready = 1'b0;
        repeat (50) tick();
        m_tready = 1'b1;
        drain(20, "bp_drain");
        check_val("bp_terr", 32'(terr_count), 32'd0);
        check_val("bp_len", 32'(out_log.size()), 32'd3);
        for (int j = 0; j < 3 && j < out_log.size(); j++) begin
            exp_b = {(j == 2), 8'(8'hA0 + 8'(j))};
            check_val("bp_byte", 32'(out_log[j]), 32'(exp_b));
        end

        // Step 5: port 0 sends one byte without tlast and stalls; port 1 waits.
        $display("[TB] watchdog");
        clear_logs();
        txq[0].push_back({1'b0, 8'h55});
        push_packet(1, 2, 8'h60);
        drain(80, "wd_drain");
        check_val("wd_terr", 32'(terr_count), 32'd1);
        check_val("wd_pkts", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check_val("wd_first",  32'(grant_log[0]), 32'b001);
            check_val("wd_second", 32'(grant_log[1]), 32'b010);
        end
        check_val("wd_len", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check_val("wd_b0", 32'(out_log[0]), 32'h055);
            check_val("wd_b1", 32'(out_log[1]), 32'h060);
            check_val("wd_b2", 32'(out_log[2]), 32'h161);
        end

        // Step 6: reset in the middle of a 5-byte port 0 packet.
        $display("[TB] reset mid packet");
        clear_logs();
        push_packet(0, 5, 8'hC0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_val("ar_grant",    32'(grant),       32'd0);
        check_val("ar_busy",     32'(busy),        32'd0);
        check_val("ar_m_tvalid", 32'(m_tvalid),    32'd0);
        check_val("ar_m_tdata",  32'(m_tdata),     32'd0);
        check_val("ar_m_tlast",  32'(m_tlast),     32'd0);
        check_val("ar_s_tready", 32'(s_tready),    32'd0);
        check_val("ar_terr",     32'(timeout_err), 32'd0);
        check_val("ar_len",      32'(out_log.size()), 32'd2);
        for (int i = 0; i < PORTS; i++) txq[i].delete();
        model_reset();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_grant = '0;
        clear_logs();
        push_packet(2, 1, 8'hE0);
        push_packet(0, 1, 8'hD0);
        tick();
        check_val("ar_first_grant", 32'(grant), 32'b001);
        drain(20, "ar_drain");
        check_val("ar_pkts", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check_val("ar_second", 32'(grant_log[1]), 32'b100);

        // Step 7: randomized traffic with valid gaps and backpressure.
        $display("[TB] random traffic");
        clear_logs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (txq[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_packet(i, int'($urandom_range(1, 4)), 8'($urandom));
                hold[i] = ($urandom_range(0, 9) == 0);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end
        hold     = '0;
        m_tready = 1'b1;
        drain(300, "rnd_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
